// File: rtl/outer_prod_mm_ctrl.sv
// outer_prod_mm_ctrl: accumulates K outer products of 2x1 A columns and 1x2 B rows into a saturating 2x2 tile.
// Revision 1.0 - initial release.
`default_nettype none

// mult_2x1_1x2: registered 2x1 by 1x2 fixed-point outer product, results rounded toward zero.
module mult_2x1_1x2 #(
  parameter int BIT_NUM  = 18,
  parameter int FRAC_NUM = 9
) (
  input  logic                      clk,
  input  logic                      srst_n,
  input  logic signed [BIT_NUM-1:0] A_00,
  input  logic signed [BIT_NUM-1:0] A_10,
  input  logic signed [BIT_NUM-1:0] B_00,
  input  logic signed [BIT_NUM-1:0] B_01,
  output logic signed [BIT_NUM-1:0] C_00,
  output logic signed [BIT_NUM-1:0] C_01,
  output logic signed [BIT_NUM-1:0] C_10,
  output logic signed [BIT_NUM-1:0] C_11
);
  localparam int W = 2 * BIT_NUM;
  localparam logic signed [W-1:0] ONE_W = 1;

  // Arithmetic shift floors; an inexact negative product gets +1 LSB so it truncates toward zero.
  function automatic logic signed [BIT_NUM-1:0] fx_mul(
    input logic signed [BIT_NUM-1:0] a,
    input logic signed [BIT_NUM-1:0] b
  );
    logic signed [W-1:0] aw;
    logic signed [W-1:0] bw;
    logic signed [W-1:0] full;
    logic signed [W-1:0] sh;
    aw   = {{BIT_NUM{a[BIT_NUM-1]}}, a};
    bw   = {{BIT_NUM{b[BIT_NUM-1]}}, b};
    full = aw * bw;
    sh   = full >>> FRAC_NUM;
    if (full[W-1] && (|full[FRAC_NUM-1:0]))
      sh = sh + ONE_W;
    return sh[BIT_NUM-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      C_00 <= '0;
      C_01 <= '0;
      C_10 <= '0;
      C_11 <= '0;
    end else begin
      C_00 <= fx_mul(A_00, B_00);
      C_01 <= fx_mul(A_00, B_01);
      C_10 <= fx_mul(A_10, B_00);
      C_11 <= fx_mul(A_10, B_01);
    end
  end
endmodule

module outer_prod_mm_ctrl #(
  parameter int BIT_NUM  = 18,
  parameter int FRAC_NUM = 9
) (
  input  logic                      clk,
  input  logic                      srst_n,
  input  logic                      start,
  input  logic [4:0]                k_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [BIT_NUM-1:0] in_a0,
  input  logic signed [BIT_NUM-1:0] in_a1,
  input  logic signed [BIT_NUM-1:0] in_b0,
  input  logic signed [BIT_NUM-1:0] in_b1,
  output logic signed [BIT_NUM-1:0] out_c00,
  output logic signed [BIT_NUM-1:0] out_c01,
  output logic signed [BIT_NUM-1:0] out_c10,
  output logic signed [BIT_NUM-1:0] out_c11,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      sat_flag
);
  localparam logic [BIT_NUM-1:0] SAT_MAX = {1'b0, {(BIT_NUM-1){1'b1}}};
  localparam logic [BIT_NUM-1:0] SAT_MIN = {1'b1, {(BIT_NUM-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [4:0]         beat_cnt;
  logic               prod_vld;
  logic               accept;
  logic               job_start;
  logic [BIT_NUM-1:0] prod     [4];
  logic [BIT_NUM-1:0] acc      [4];
  logic [BIT_NUM-1:0] lane_sum [4];
  logic [BIT_NUM:0]   wide     [4];
  logic [3:0]         lane_sat;

  mult_2x1_1x2 #(
    .BIT_NUM  (BIT_NUM),
    .FRAC_NUM (FRAC_NUM)
  ) u_mult (
    .clk    (clk),
    .srst_n (srst_n),
    .A_00   (in_a0),
    .A_10   (in_a1),
    .B_00   (in_b0),
    .B_01   (in_b1),
    .C_00   (prod[0]),
    .C_01   (prod[1]),
    .C_10   (prod[2]),
    .C_11   (prod[3])
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    job_start = 1'b0;
    case (state)
      IDLE: begin
        if (start && (k_len != 5'd0)) begin
          job_start = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && (beat_cnt == 5'd1))
          state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      prod_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      prod_vld <= accept;
      if (job_start)
        beat_cnt <= k_len;
      else if (accept)
        beat_cnt <= beat_cnt - 5'd1;
    end
  end

  // One guard bit catches overflow; clamp to the signed range of the tile.
  always_comb begin
    lane_sat = '0;
    for (int i = 0; i < 4; i++) begin
      wide[i]     = {acc[i][BIT_NUM-1], acc[i]} + {prod[i][BIT_NUM-1], prod[i]};
      lane_sum[i] = wide[i][BIT_NUM-1:0];
      if (wide[i][BIT_NUM] != wide[i][BIT_NUM-1]) begin
        lane_sat[i] = 1'b1;
        lane_sum[i] = wide[i][BIT_NUM] ? SAT_MIN : SAT_MAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      for (int i = 0; i < 4; i++)
        acc[i] <= '0;
      sat_flag <= 1'b0;
    end else if (job_start) begin
      for (int i = 0; i < 4; i++)
        acc[i] <= '0;
      sat_flag <= 1'b0;
    end else if (prod_vld) begin
      for (int i = 0; i < 4; i++)
        acc[i] <= lane_sum[i];
      if (|lane_sat)
        sat_flag <= 1'b1;
    end
  end

  assign out_c00 = acc[0];
  assign out_c01 = acc[1];
  assign out_c10 = acc[2];
  assign out_c11 = acc[3];
endmodule

`default_nettype wire

// File: tb/tb_outer_prod_mm_ctrl.sv
// tb_outer_prod_mm_ctrl: directed vectors with hand-computed results for outer_prod_mm_ctrl.
// Revision 1.0 - initial release.
`default_nettype none

module tb_outer_prod_mm_ctrl;
  localparam int BIT_NUM  = 18;
  localparam int FRAC_NUM = 9;

  logic                      clk = 1'b0;
  logic                      srst_n;
  logic                      start;
  logic [4:0]                k_len;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [BIT_NUM-1:0] in_a0, in_a1, in_b0, in_b1;
  logic signed [BIT_NUM-1:0] out_c00, out_c01, out_c10, out_c11;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;
  logic                      sat_flag;

  int n_checks = 0;
  int n_fail   = 0;
  int n_accept;

  always #5 clk = ~clk;

  outer_prod_mm_ctrl #(
    .BIT_NUM  (BIT_NUM),
    .FRAC_NUM (FRAC_NUM)
  ) dut (
    .clk       (clk),
    .srst_n    (srst_n),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a0     (in_a0),
    .in_a1     (in_a1),
    .in_b0     (in_b0),
    .in_b1     (in_b1),
    .out_c00   (out_c00),
    .out_c01   (out_c01),
    .out_c10   (out_c10),
    .out_c11   (out_c11),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .sat_flag  (sat_flag)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a0, input int a1, input int b0, input int b1);
    in_a0 = BIT_NUM'(a0);
    in_a1 = BIT_NUM'(a1);
    in_b0 = BIT_NUM'(b0);
    in_b1 = BIT_NUM'(b1);
  endtask

  task automatic check_tile(input string tag, input int c00, input int c01, input int c10, input int c11);
    check({tag, "_c00"}, out_c00, c00);
    check({tag, "_c01"}, out_c01, c01);
    check({tag, "_c10"}, out_c10, c10);
    check({tag, "_c11"}, out_c11, c11);
  endtask

  initial begin
    srst_n    = 1'b0;
    start     = 1'b0;
    k_len     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sat", sat_flag, 0);
    check_tile("rst", 0, 0, 0, 0);

    // K=1, start on the first edge with reset released
    srst_n = 1'b1;
    start  = 1'b1;
    k_len  = 5'd1;
    tick();
    start = 1'b0;
    check("k1_busy", busy, 1);
    check("k1_in_ready", in_ready, 1);
    in_valid = 1'b1;
    drive(512, 256, 512, -512);
    tick();
    in_valid = 1'b0;
    check("k1_drain_in_ready", in_ready, 0);
    check("k1_drain_out_valid", out_valid, 0);
    tick();
    check("k1_out_valid", out_valid, 1);
    check_tile("k1", 512, -512, 256, -256);
    check("k1_sat", sat_flag, 0);
    tick();
    check("k1_idle_busy", busy, 0);
    check("k1_idle_out_valid", out_valid, 0);
    check("k1_hold_c00", out_c00, 512);

    // K=4, in_valid toggling
    start = 1'b1;
    k_len = 5'd4;
    tick();
    start    = 1'b0;
    n_accept = 0;
    drive(512, 512, 512, 512);
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      if (in_valid && in_ready) n_accept++;
      tick();
    end
    check("k4_ready_after_last", in_ready, 0);
    in_valid = 1'b1;
    if (in_valid && in_ready) n_accept++;
    tick();
    in_valid = 1'b0;
    check("k4_accepts", n_accept, 4);
    check("k4_out_valid", out_valid, 1);
    check_tile("k4", 2048, 2048, 2048, 2048);
    tick();

    // K=2 saturation
    start = 1'b1;
    k_len = 5'd2;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    drive(8192, 8192, 7680, 7680);
    tick();
    tick();
    in_valid = 1'b0;
    check("sat_partial_c00", out_c00, 122880);
    check("sat_partial_flag", sat_flag, 0);
    tick();
    check_tile("sat", 131071, 131071, 131071, 131071);
    check("sat_flag", sat_flag, 1);
    tick();
    check("sat_flag_idle", sat_flag, 1);

    // K=3 with stalled output, new job clears sat_flag
    out_ready = 1'b0;
    start     = 1'b1;
    k_len     = 5'd3;
    tick();
    start = 1'b0;
    check("k3_sat_cleared", sat_flag, 0);
    check("k3_acc_cleared", out_c00, 0);
    in_valid = 1'b1;
    drive(1024, -512, 768, -256);
    tick();
    tick();
    drive(1, -1, -1, -1);
    tick();
    in_valid = 1'b0;
    tick();
    check("k3_out_valid", out_valid, 1);
    check_tile("k3", 3072, -1024, -1536, 512);
    for (int i = 0; i < 10; i++) begin
      start    = (i % 3 == 0);
      k_len    = 5'd1;
      in_valid = 1'b1;
      tick();
      check("stall_out_valid", out_valid, 1);
      check("stall_busy", busy, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_c00", out_c00, 3072);
      check("stall_c11", out_c11, 512);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("k3_release_busy", busy, 0);
    check("k3_release_out_valid", out_valid, 0);
    check("k3_release_c01", out_c01, -1024);

    // reset after 2 of 5 beats
    start = 1'b1;
    k_len = 5'd5;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    drive(512, 512, 512, 512);
    tick();
    tick();
    in_valid = 1'b0;
    srst_n   = 1'b0;
    tick();
    check_tile("midrst", 0, 0, 0, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    srst_n = 1'b1;
    start  = 1'b1;
    k_len  = 5'd1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    drive(512, -512, 256, 1024);
    tick();
    in_valid = 1'b0;
    tick();
    check("fresh_out_valid", out_valid, 1);
    check_tile("fresh", 256, 1024, -256, -1024);
    tick();

    // k_len=0 start ignored
    start = 1'b1;
    k_len = 5'd0;
    tick();
    start = 1'b0;
    check("k0_busy", busy, 0);
    check("k0_in_ready", in_ready, 0);
    check("k0_out_valid", out_valid, 0);
    check("k0_c00", out_c00, 256);
    check("k0_c11", out_c11, -1024);
    tick();
    check("k0_busy_later", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
